// File: rtl/add_op_impl_pipelined_if.sv
// ---------------------------------------------------------------------------
// add_op_impl_pipelined_if
// Purpose : Valid/ready operand and result bundle for the pipelined add op.
//           The master (the ALU dispatch or a harness) drives the operands and
//           the result-side ready. The slave (the adder) returns in_ready and
//           the registered result beat.
// Signals :
//   in_valid  m->s  operand beat valid
//   in_ready  s->m  adder can take a beat this cycle
//   lhs       m->s  left operand  [OPERAND_WIDTH]
//   rhs       m->s  right operand [OPERAND_WIDTH]
//   carry_in  m->s  carry into bit 0
//   sub       m->s  subtract select (only when ADD_OP_SUB_EN is defined)
//   out_valid s->m  result beat valid
//   out_ready m->s  master accepts the result this cycle
//   result    s->m  sum modulo 2^OPERAND_WIDTH
//   carry_out s->m  carry out of the MSB
//   overflow  s->m  signed two's-complement overflow
// Config  : ADD_OP_SUB_EN adds the sub signal.
// ---------------------------------------------------------------------------
interface add_op_impl_pipelined_if #(
  parameter int OPERAND_WIDTH = 32
);
  logic                     in_valid;
  logic                     in_ready;
  logic [OPERAND_WIDTH-1:0] lhs;
  logic [OPERAND_WIDTH-1:0] rhs;
  logic                     carry_in;
`ifdef ADD_OP_SUB_EN
  logic                     sub;
`endif
  logic                     out_valid;
  logic                     out_ready;
  logic [OPERAND_WIDTH-1:0] result;
  logic                     carry_out;
  logic                     overflow;

  modport master (
`ifdef ADD_OP_SUB_EN
    output sub,
`endif
    output in_valid, lhs, rhs, carry_in, out_ready,
    input  in_ready, out_valid, result, carry_out, overflow
  );

  modport slave (
`ifdef ADD_OP_SUB_EN
    input  sub,
`endif
    input  in_valid, lhs, rhs, carry_in, out_ready,
    output in_ready, out_valid, result, carry_out, overflow
  );
endinterface

// File: rtl/add_op_impl_pipelined.sv
// ---------------------------------------------------------------------------
// add_op_impl_pipelined
// Purpose : Segmented ripple adder. Each pipeline stage sums one SEGMENT_WIDTH
//           slice and passes its carry to the next stage. The higher operand
//           slices and the lower result slices travel alongside in the stage
//           registers. Latency is NUM_STAGES = OPERAND_WIDTH/SEGMENT_WIDTH
//           cycles and throughput is one op per cycle. The whole pipe stalls
//           when the output holds an unaccepted beat.
// Ports   :
//   clk      in   sole clock, rising edge
//   rst      in   synchronous, active-high reset; discards in-flight ops
//   add_bus  slave modport of add_op_impl_pipelined_if (operands in, result out)
// Config  : ADD_OP_SUB_EN enables the sub input. The adder then computes
//           lhs + ~rhs + (carry_in ^ sub) when sub is set.
// ---------------------------------------------------------------------------
module add_op_impl_pipelined #(
  parameter int OPERAND_WIDTH = 32,
  parameter int SEGMENT_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  add_op_impl_pipelined_if.slave        add_bus
);

  // A guarded slice width keeps elaboration arithmetic defined on a bad config.
  localparam int W          = OPERAND_WIDTH;
  localparam int SEG_W      = (SEGMENT_WIDTH > 0) ? SEGMENT_WIDTH : 1;
  localparam int NUM_STAGES = ((OPERAND_WIDTH / SEG_W) > 0) ? (OPERAND_WIDTH / SEG_W) : 1;

  if ((SEGMENT_WIDTH <= 0) || ((OPERAND_WIDTH % SEG_W) != 0)) begin : g_cfg_err
    $error("add_op_impl_pipelined: SEGMENT_WIDTH must be nonzero and divide OPERAND_WIDTH");
  end

  // Stage registers. Index NUM_STAGES-1 is the output stage.
  logic         r_vld [NUM_STAGES];
  logic [W-1:0] r_lhs [NUM_STAGES];
  logic [W-1:0] r_rhs [NUM_STAGES];   // holds the effective (possibly inverted) rhs
  logic [W-1:0] r_sum [NUM_STAGES];
  logic         r_cy  [NUM_STAGES];
  logic         r_ovf;

  // Per-stage inputs (previous stage or the bus) and next-state values.
  logic         w_vld_src [NUM_STAGES];
  logic [W-1:0] w_lhs_src [NUM_STAGES];
  logic [W-1:0] w_rhs_src [NUM_STAGES];
  logic [W-1:0] w_sum_src [NUM_STAGES];
  logic         w_cy_src  [NUM_STAGES];
  logic [W-1:0] w_sum_nxt [NUM_STAGES];
  logic         w_cy_nxt  [NUM_STAGES];
  logic [SEG_W:0] w_seg   [NUM_STAGES];

  logic         w_advance;
  logic [W-1:0] w_rhs_eff;
  logic         w_cin_eff;
  logic         w_ovf_nxt;

  // Subtraction folds into the operands at entry, so sub travels with its beat.
`ifdef ADD_OP_SUB_EN
  assign w_rhs_eff = add_bus.sub ? ~add_bus.rhs : add_bus.rhs;
  assign w_cin_eff = add_bus.carry_in ^ add_bus.sub;
`else
  assign w_rhs_eff = add_bus.rhs;
  assign w_cin_eff = add_bus.carry_in;
`endif

  // The pipe moves whenever the output slot is empty or being drained.
  assign w_advance        = !r_vld[NUM_STAGES-1] || add_bus.out_ready;
  assign add_bus.in_ready = w_advance;

  // Route each stage's source: stage 0 from the bus, others from the prior stage.
  always_comb begin
    w_vld_src[0] = add_bus.in_valid;
    w_lhs_src[0] = add_bus.lhs;
    w_rhs_src[0] = w_rhs_eff;
    w_sum_src[0] = {W{1'b0}};
    w_cy_src[0]  = w_cin_eff;
    for (int k = 1; k < NUM_STAGES; k++) begin
      w_vld_src[k] = r_vld[k-1];
      w_lhs_src[k] = r_lhs[k-1];
      w_rhs_src[k] = r_rhs[k-1];
      w_sum_src[k] = r_sum[k-1];
      w_cy_src[k]  = r_cy[k-1];
    end
  end

  // Stage k adds slice k and patches it into the partial result word.
  always_comb begin
    for (int k = 0; k < NUM_STAGES; k++) begin
      w_seg[k] = {1'b0, w_lhs_src[k][k*SEG_W +: SEG_W]}
               + {1'b0, w_rhs_src[k][k*SEG_W +: SEG_W]}
               + {{SEG_W{1'b0}}, w_cy_src[k]};
      w_sum_nxt[k] = w_sum_src[k];
      w_sum_nxt[k][k*SEG_W +: SEG_W] = w_seg[k][SEG_W-1:0];
      w_cy_nxt[k]  = w_seg[k][SEG_W];
    end
  end

  // Signed overflow is settled once the last slice (holding the sign bit) is summed.
  assign w_ovf_nxt = (w_lhs_src[NUM_STAGES-1][W-1] == w_rhs_src[NUM_STAGES-1][W-1])
                  && (w_sum_nxt[NUM_STAGES-1][W-1] != w_lhs_src[NUM_STAGES-1][W-1]);

  // Stage registers: clear on reset, shift on advance, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        r_vld[k] <= 1'b0;
        r_lhs[k] <= {W{1'b0}};
        r_rhs[k] <= {W{1'b0}};
        r_sum[k] <= {W{1'b0}};
        r_cy[k]  <= 1'b0;
      end
      r_ovf <= 1'b0;
    end else if (w_advance) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        r_vld[k] <= w_vld_src[k];
        r_lhs[k] <= w_lhs_src[k];
        r_rhs[k] <= w_rhs_src[k];
        r_sum[k] <= w_sum_nxt[k];
        r_cy[k]  <= w_cy_nxt[k];
      end
      r_ovf <= w_ovf_nxt;
    end else begin
      r_ovf <= r_ovf;
    end
  end

  assign add_bus.out_valid = r_vld[NUM_STAGES-1];
  assign add_bus.result    = r_sum[NUM_STAGES-1];
  assign add_bus.carry_out = r_cy[NUM_STAGES-1];
  assign add_bus.overflow  = r_ovf;

endmodule
